// File: rtl/mx_block_seq.sv
// rtl/mx_block_seq.sv - 32-element FP32 block buffer with shared E5M2-style power-of-two scale
module mx_block_seq #(
    parameter int SCALE_OFFSET = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [32:1] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:1] out_data,
    output logic [8:1]  out_scale,
    output logic        out_last
);

    localparam logic [7:0] OFFSET = 8'(SCALE_OFFSET);

    typedef enum logic [1:0] {
        COLLECT,
        SCALE,
        EMIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  wcnt;
    logic [4:0]  rcnt;
    logic [31:1] max_q;
    logic [32:1] mem [0:31];
    logic        accept;
    logic        emit;
    logic [7:0]  scale_next;
    logic [7:0]  max_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        emit       = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && wcnt == 5'd31) begin
                    state_next = SCALE;
                end
            end
            SCALE: begin
                state_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                emit      = out_ready;
                if (out_ready && rcnt == 5'd31) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Unsigned compare of the magnitude bits orders NaN > Inf > finite.
    always_comb begin
        max_exp    = max_q[31:24];
        scale_next = 8'h00;
        if (max_exp == 8'hFF) begin
            scale_next = (|max_q[23:1]) ? 8'hFF : 8'hFE;
        end else if (max_exp > OFFSET) begin
            scale_next = max_exp - OFFSET;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt      <= 5'd0;
            rcnt      <= 5'd0;
            max_q     <= '0;
            out_scale <= 8'h00;
        end else begin
            if (accept) begin
                wcnt <= wcnt + 5'd1;
                if (in_data[31:1] > max_q) begin
                    max_q <= in_data[31:1];
                end
            end
            if (state == SCALE) begin
                out_scale <= scale_next;
                max_q     <= '0;
            end
            if (emit) begin
                rcnt <= rcnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wcnt] <= in_data;
        end
    end

    assign out_data = mem[rcnt];
    assign out_last = out_valid && (rcnt == 5'd31);

endmodule

// File: tb/tb_mx_block_seq.sv
// tb/tb_mx_block_seq.sv - randomized self-checking bench for mx_block_seq against a queue-based block model
module tb_mx_block_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [32:1] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [32:1] out_data;
    logic [8:1]  out_scale;
    logic        out_last;

    always #5 clk = ~clk;

    mx_block_seq #(.SCALE_OFFSET(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_scale (out_scale),
        .out_last  (out_last)
    );

    int tests = 0;
    int fails = 0;

    bit [31:0] feed[$];
    bit [31:0] cur[$];
    bit [31:0] out_q[$];
    bit [31:0] blk_saved[$];
    bit [31:0] got[0:31];
    int        exp_scale = 0;
    int        pending_scale = 0;
    bit        gap = 1'b0;
    bit        model_ok = 1'b0;
    bit        rst_req = 1'b1;
    bit        prev_ov = 1'b0;
    int        p_valid = 100;
    int        p_ready = 100;
    int        cyc = 0;
    int        last_acc_cyc = 0;
    int        lat = -1;
    int        first_scale = -1;
    int        gidx = 0;
    int        emitted_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Largest magnitude with the sign bit masked, then the four scale rules.
    function automatic int model_scale(input bit [31:0] blk[$]);
        bit [31:0] m;
        int        e;
        int        man;
        m = 0;
        foreach (blk[i]) begin
            if ((blk[i] & 32'h7FFF_FFFF) > m) m = blk[i] & 32'h7FFF_FFFF;
        end
        e   = int'(m >> 23);
        man = int'(m & 32'h007F_FFFF);
        if (e == 255) return (man != 0) ? 255 : 254;
        if (e <= 15) return 0;
        return e - 15;
    endfunction

    always @(negedge clk) begin
        bit m_ir;
        bit m_ov;
        cyc++;
        if (model_ok) begin
            m_ov = out_q.size() > 0;
            m_ir = !gap && !m_ov;
            check("in_ready", 32'(in_ready), 32'(m_ir));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("out_scale", 32'(out_scale), 32'(exp_scale));
            if (m_ov) begin
                check("out_data", out_data, out_q[0]);
                check("out_last", 32'(out_last), 32'(out_q.size() == 1));
                if (!prev_ov) begin
                    lat         = cyc - last_acc_cyc;
                    first_scale = int'(out_scale);
                end
            end
        end
        prev_ov = out_valid;

        if (rst_req) begin
            rst      = 1'b1;
            rst_req  = 1'b0;
            in_valid = 1'b0;
            in_data  = $urandom;
            feed.delete();
        end else begin
            rst      = 1'b0;
            in_valid = (feed.size() > 0) && (($urandom % 100) < p_valid);
            in_data  = in_valid ? feed[0] : $urandom;
        end
        out_ready = ($urandom % 100) < p_ready;

        #1;
        if (rst) begin
            cur.delete();
            out_q.delete();
            gap       = 1'b0;
            exp_scale = 0;
            prev_ov   = 1'b0;
            model_ok  = 1'b1;
        end else if (model_ok) begin
            if (gap) begin
                exp_scale = pending_scale;
                out_q     = blk_saved;
                gap       = 1'b0;
            end else if (out_q.size() > 0) begin
                if (out_ready) begin
                    got[gidx % 32] = out_data;
                    gidx++;
                    emitted_total++;
                    void'(out_q.pop_front());
                end
            end else if (in_valid) begin
                void'(feed.pop_front());
                cur.push_back(in_data);
                if (cur.size() == 32) begin
                    pending_scale = model_scale(cur);
                    blk_saved     = cur;
                    cur.delete();
                    gap          = 1'b1;
                    last_acc_cyc = cyc;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(feed.size() == 0 && cur.size() == 0 && !gap && out_q.size() == 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no drain, expected idle within 3000 cycles", name);
        end
    endtask

    task automatic run_block(input bit [31:0] words[$], input string name, input int scale_lit);
        gidx = 0;
        lat  = -1;
        foreach (words[i]) feed.push_back(words[i]);
        step();
        wait_idle(name);
        check({name, "_scale"}, 32'(first_scale), 32'(scale_lit));
        check({name, "_latency"}, 32'(lat), 32'd2);
        check({name, "_beats"}, 32'(gidx), 32'd32);
    endtask

    initial begin
        bit [31:0] w[$];
        int        n;
        bit [31:0] pin[$];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        n = 0;
        while (!model_ok && n < 20) begin
            step();
            n++;
        end
        step();
        check("reset_scale", 32'(out_scale), 32'h00);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);

        pin = {32'h3F80_0000, 32'hC380_0000};
        check("model_pin_sign", 32'(model_scale(pin)), 32'h78);
        pin = {32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0001};
        check("model_pin_nan", 32'(model_scale(pin)), 32'hFF);

        p_valid = 100;
        p_ready = 100;
        w.delete();
        for (int i = 0; i < 32; i++) w.push_back(32'h3F80_0000);
        run_block(w, "ones", 8'h70);
        check("ones_beat31", got[31], 32'h3F80_0000);

        w[17] = 32'hC380_0000;
        run_block(w, "neg17", 8'h78);
        check("neg17_beat17", got[17], 32'hC380_0000);
        check("neg17_beat16", got[16], 32'h3F80_0000);

        w.delete();
        for (int i = 0; i < 32; i++) w.push_back(32'h0000_0000);
        run_block(w, "zeros", 8'h00);
        w.delete();
        for (int i = 0; i < 32; i++) w.push_back(32'h0780_0000);
        run_block(w, "exp0f", 8'h00);

        w.delete();
        for (int i = 0; i < 32; i++) w.push_back({1'b0, 8'($urandom_range(1, 200)), 23'($urandom)});
        w[$urandom_range(0, 31)] = 32'h7F80_0000;
        run_block(w, "inf", 8'hFE);
        w[5]  = 32'h7F80_0000;
        w[20] = 32'h7FC0_0000;
        run_block(w, "nan", 8'hFF);

        // Three back-to-back random blocks with input gaps and output stalls.
        p_valid = 60;
        p_ready = 60;
        emitted_total = 0;
        for (int i = 0; i < 96; i++) feed.push_back($urandom);
        step();
        wait_idle("random");
        check("random_total_beats", 32'(emitted_total), 32'd96);

        // Reset during collection at about wcnt=10.
        p_valid = 100;
        p_ready = 100;
        for (int i = 0; i < 32; i++) feed.push_back(32'h7F00_0000);
        n = 0;
        while (cur.size() < 10 && n < 200) begin
            step();
            n++;
        end
        rst_req = 1'b1;
        repeat (3) step();
        w.delete();
        for (int i = 0; i < 32; i++) w.push_back(32'h3F80_0000);
        run_block(w, "rst_collect", 8'h70);

        // Reset during emission at about rcnt=5.
        gidx = 0;
        for (int i = 0; i < 32; i++) feed.push_back(32'h7F00_0000);
        n = 0;
        while (gidx < 5 && n < 200) begin
            step();
            n++;
        end
        rst_req = 1'b1;
        repeat (3) step();
        w.delete();
        for (int i = 0; i < 32; i++) w.push_back(32'h4000_0000);
        run_block(w, "rst_emit", 8'h71);
        check("rst_emit_beat0", got[0], 32'h4000_0000);

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
